// File: rtl/puf_sequencer.sv
// puf_sequencer: runs a burst of challenges through a serial ring-oscillator PUF.
// Each challenge step goes CLEAR -> SETTLE -> WAIT -> OUTPUT. The response
// (or a timeout marker) is then handed to the host before the next step starts.
//
// Host handshake (valid/ready): resp_valid is high only in OUTPUT. While it
// is high, resp_data, resp_index and resp_timeout do not change. A transfer
// happens on a rising clock edge where resp_valid and resp_ready are both 1.
// resp_valid drops in the cycle after the transfer. resp_ready has no effect
// while resp_valid is low.
module puf_sequencer #(
    parameter int CLEAR_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  base_challenge,
    input  logic [3:0]  num_challenges,
    output logic        busy,
    output logic [7:0]  puf_challenge,
    output logic [31:0] puf_enable,
    output logic        puf_reset,
    input  logic        puf_done,
    input  logic [7:0]  puf_response,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_data,
    output logic [3:0]  resp_index,
    output logic        resp_timeout,
    output logic        burst_done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    // Each counter is just wide enough to reach its own cycle count.
    localparam int CLR_W = (CLEAR_CYCLES   > 1) ? $clog2(CLEAR_CYCLES + 1)   : 1;
    localparam int SET_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES + 1)  : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t next_state;

    logic [CLR_W-1:0] clear_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [TMO_W-1:0] wait_cnt;

    logic [7:0] challenge;
    logic [3:0] burst_len;
    logic [3:0] index;

    logic clear_last;
    logic settle_last;
    logic wait_expire;
    logic handshake;
    logic step_last;

    // Decode the conditions shared by the FSM and the datapath.
    always_comb begin
        clear_last  = (clear_cnt == CLR_LAST);
        settle_last = (settle_cnt == SET_LAST);
        wait_expire = (wait_cnt == TMO_LAST);
        handshake   = (state == ST_OUTPUT) && resp_ready;
        // A stored length of 0 wraps to 15 here, which gives a 16-step burst.
        step_last   = (index == (burst_len - 4'd1));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the outputs decoded from the state.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        puf_enable = 32'h0000_0000;
        puf_reset  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                puf_reset = 1'b1;
                if (start) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                puf_reset = 1'b1;
                if (clear_last) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // puf_done is ignored here because the oscillators are still settling.
                puf_enable = 32'hFFFF_FFFF;
                if (settle_last) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                puf_enable = 32'hFFFF_FFFF;
                if (puf_done || wait_expire) begin
                    next_state = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = step_last ? ST_IDLE : ST_CLEAR;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Per-state cycle counters. Each is held at zero outside its own state,
    // so it starts from zero every time that state is entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            clear_cnt  <= '0;
            settle_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            clear_cnt  <= (state == ST_CLEAR)  ? clear_cnt + 1'b1  : '0;
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            wait_cnt   <= (state == ST_WAIT)   ? wait_cnt + 1'b1   : '0;
        end
    end

    // Burst bookkeeping, response capture and the burst_done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            challenge    <= 8'h00;
            burst_len    <= 4'd0;
            index        <= 4'd0;
            resp_data    <= 8'h00;
            resp_timeout <= 1'b0;
            burst_done   <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        challenge <= base_challenge;
                        burst_len <= num_challenges;
                        index     <= 4'd0;
                    end
                end
                ST_WAIT: begin
                    // A real response takes priority over a timeout in the same cycle.
                    if (puf_done) begin
                        resp_data    <= puf_response;
                        resp_timeout <= 1'b0;
                    end else if (wait_expire) begin
                        resp_data    <= 8'h00;
                        resp_timeout <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (handshake) begin
                        if (step_last) begin
                            burst_done <= 1'b1;
                        end else begin
                            challenge <= challenge + 8'd1;
                            index     <= index + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign puf_challenge = challenge;
    assign resp_index    = index;
    assign state_dbg     = state;

endmodule

// File: tb/tb_puf_sequencer.sv
// Bench for puf_sequencer with short timing parameters.
// Expected responses are queued as each PUF response (or timeout) is set up.
// A monitor pops the queue on every host handshake.
module tb_puf_sequencer;

    localparam int CLEAR_CYCLES   = 2;
    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 20;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  base_challenge;
    logic [3:0]  num_challenges;
    logic        busy;
    logic [7:0]  puf_challenge;
    logic [31:0] puf_enable;
    logic        puf_reset;
    logic        puf_done;
    logic [7:0]  puf_response;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_data;
    logic [3:0]  resp_index;
    logic        resp_timeout;
    logic        burst_done;
    logic [2:0]  state_dbg;

    int checks;
    int errors;
    int bd_count;
    logic [12:0] exp_q[$];
    logic [12:0] exp_e;

    puf_sequencer #(
        .CLEAR_CYCLES  (CLEAR_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base_challenge(base_challenge),
        .num_challenges(num_challenges),
        .busy          (busy),
        .puf_challenge (puf_challenge),
        .puf_enable    (puf_enable),
        .puf_reset     (puf_reset),
        .puf_done      (puf_done),
        .puf_response  (puf_response),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_index    (resp_index),
        .resp_timeout  (resp_timeout),
        .burst_done    (burst_done),
        .state_dbg     (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: a transfer completes at the next rising edge.
    always @(negedge clock) begin
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(1), 32'(0));
            end else begin
                exp_e = exp_q.pop_front();
                check("sb_data",    32'(resp_data),    32'(exp_e[7:0]));
                check("sb_index",   32'(resp_index),   32'(exp_e[11:8]));
                check("sb_timeout", 32'(resp_timeout), 32'(exp_e[12]));
            end
        end
        if (burst_done) bd_count++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_busy",      32'(busy),          32'(0));
        check("rst_enable",    puf_enable,         32'(0));
        check("rst_puf_reset", 32'(puf_reset),     32'(1));
        check("rst_chal",      32'(puf_challenge), 32'(0));
        check("rst_valid",     32'(resp_valid),    32'(0));
        check("rst_data",      32'(resp_data),     32'(0));
        check("rst_index",     32'(resp_index),    32'(0));
        check("rst_timeout",   32'(resp_timeout),  32'(0));
        check("rst_bdone",     32'(burst_done),    32'(0));
    endtask

    task automatic start_burst(input logic [7:0] base, input logic [3:0] num);
        start          = 1'b1;
        base_challenge = base;
        num_challenges = num;
        step();
        start          = 1'b0;
        base_challenge = $urandom_range(0, 255);
        num_challenges = $urandom_range(0, 15);
    endtask

    // One challenge step, entered at the first CLEAR cycle.
    task automatic run_step(input logic [7:0] chal, input logic [3:0] idx, input bit last,
                            input bit tmo, input logic [7:0] resp, input int dly, input int hold);
        int n;
        logic [12:0] exp_v;
        check("clr_chal",   32'(puf_challenge), 32'(chal));
        check("clr_reset",  32'(puf_reset),     32'(1));
        check("clr_busy",   32'(busy),          32'(1));
        n = 0;
        while (puf_enable != 32'hFFFF_FFFF && n < 50) begin
            step();
            n++;
        end
        check("clear_len", 32'(n), 32'(CLEAR_CYCLES));
        check("settle_reset", 32'(puf_reset), 32'(0));
        // A spurious done during SETTLE must not end the step early.
        puf_done     = 1'($urandom_range(0, 1));
        puf_response = 8'hEE;
        repeat (SETTLE_CYCLES) step();
        puf_done = 1'b0;
        check("wait_entry_valid", 32'(resp_valid), 32'(0));
        check("wait_enable",      puf_enable,      32'hFFFF_FFFF);
        check("wait_chal",        32'(puf_challenge), 32'(chal));
        if (tmo) begin
            repeat (TIMEOUT_CYCLES - 1) step();
            check("tmo_early", 32'(resp_valid), 32'(0));
            exp_v = {1'b1, idx, 8'h00};
            exp_q.push_back(exp_v);
            step();
        end else begin
            repeat (dly) step();
            puf_done     = 1'b1;
            puf_response = resp;
            exp_v = {1'b0, idx, resp};
            exp_q.push_back(exp_v);
            step();
            puf_done     = 1'b0;
            puf_response = $urandom_range(0, 255);
        end
        check("out_valid", 32'(resp_valid), 32'(1));
        check("out_chal",  32'(puf_challenge), 32'(chal));
        resp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            check("bp_valid",   32'(resp_valid),   32'(1));
            check("bp_data",    32'(resp_data),    32'(exp_v[7:0]));
            check("bp_index",   32'(resp_index),   32'(idx));
            check("bp_timeout", 32'(resp_timeout), 32'(exp_v[12]));
            check("bp_no_clear", 32'(puf_reset),   32'(0));
            step();
        end
        start = 1'b0;
        check("pre_hs_index", 32'(resp_index), 32'(idx));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("post_hs_valid", 32'(resp_valid), 32'(0));
        if (last) begin
            check("bdone_pulse", 32'(burst_done), 32'(1));
            check("idle_busy",   32'(busy),       32'(0));
            step();
            check("bdone_clear", 32'(burst_done), 32'(0));
        end else begin
            check("mid_bdone", 32'(burst_done), 32'(0));
            check("next_clear", 32'(puf_reset), 32'(1));
        end
    endtask

    task automatic run_burst(input logic [7:0] base, input logic [3:0] num, input bit tmo,
                             input int hold, input int first_resp, input int dly);
        int len;
        logic [7:0] r;
        int d;
        len = (num == 4'd0) ? 16 : int'(num);
        start_burst(base, num);
        for (int i = 0; i < len; i++) begin
            r = (first_resp < 0) ? 8'($urandom_range(0, 255)) : 8'(first_resp + i);
            d = (dly < 0) ? int'($urandom_range(0, TIMEOUT_CYCLES - 2)) : dly;
            run_step(8'(int'(base) + i), 4'(i), (i == len - 1), tmo, r, d, hold);
        end
    endtask

    // Main sequence.
    initial begin
        int bd0;
        checks         = 0;
        errors         = 0;
        bd_count       = 0;
        reset          = 1'b0;
        start          = 1'b0;
        base_challenge = 8'h00;
        num_challenges = 4'd0;
        puf_done       = 1'b0;
        puf_response   = 8'h00;
        resp_ready     = 1'b0;
        step();
        step();
        check_reset_vals();
        reset = 1'b1;
        step();

        // Single step with the response three cycles into WAIT.
        run_burst(8'h3C, 4'd1, 1'b0, 0, 8'hA5, 3);

        // Challenge wraps from FF to 00 inside one burst.
        bd0 = bd_count;
        run_burst(8'hFE, 4'd3, 1'b0, 0, 1, -1);
        step();
        check("wrap_bdone_count", 32'(bd_count - bd0), 32'(1));

        // Timeout with no puf_done at all.
        run_burst(8'h55, 4'd1, 1'b1, 0, -1, -1);

        // puf_done arrives in the same cycle the timeout would expire.
        run_burst(8'h77, 4'd1, 1'b0, 0, 8'h5A, TIMEOUT_CYCLES - 1);

        // Host backpressure with start pulses during the hold.
        run_burst(8'h10, 4'd2, 1'b0, 10, -1, -1);

        // Length 0 means a 16-step burst.
        run_burst(8'h80, 4'd0, 1'b0, 0, -1, -1);
        check("len16_idle", 32'(busy), 32'(0));

        // Reset while waiting in the second step, with start held through reset.
        start_burst(8'h40, 4'd3);
        run_step(8'h40, 4'd0, 1'b0, 1'b0, 8'h11, 2, 0);
        repeat (CLEAR_CYCLES + SETTLE_CYCLES + 2) step();
        check("pre_reset_wait", puf_enable, 32'hFFFF_FFFF);
        reset = 1'b0;
        start = 1'b1;
        step();
        check_reset_vals();
        reset = 1'b1;
        start = 1'b0;
        step();
        check("start_in_reset_ignored", 32'(busy), 32'(0));
        run_burst(8'h40, 4'd2, 1'b0, 0, -1, -1);

        step();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_sequencer.md
PUF_SEQUENCER -- requirements
Module: puf_sequencer

Interface
REQ-001 Parameter CLEAR_CYCLES, default 2: cycles puf_reset is held in CLEAR (range 1..15).
REQ-002 Parameter SETTLE_CYCLES, default 4: cycles oscillators run before done is watched (range 1..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: maximum WAIT duration (range 1..2^24-1).
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to run a burst; sampled only in IDLE.
REQ-007 base_challenge  in  8  first challenge of the burst.
REQ-008 num_challenges  in  4  burst length; 0 means 16.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 puf_challenge  out  8  challenge driven to the serial PUF.
REQ-011 puf_enable  out  32  ring-oscillator enables; all ones in SETTLE and WAIT, else zero.
REQ-012 puf_reset  out  1  active-high reset/ack to the PUF; high in IDLE and CLEAR, else low.
REQ-013 puf_done  in  1  PUF response-ready flag.
REQ-014 puf_response  in  8  PUF response byte.
REQ-015 resp_valid  out  1  response available to the host.
REQ-016 resp_ready  in  1  host accepts response.
REQ-017 resp_data  out  8  captured response.
REQ-018 resp_index  out  4  position of response in burst, 0-based.
REQ-019 resp_timeout  out  1  response was produced by timeout, not by puf_done.
REQ-020 burst_done  out  1  one-cycle pulse after last response is accepted.

Function
REQ-021 FSM states: IDLE, CLEAR, SETTLE, WAIT, OUTPUT; exactly one active.
REQ-022 IDLE with start=1: latch base_challenge into the challenge register, latch num_challenges, clear index; next state CLEAR.
REQ-023 start in any state other than IDLE is ignored; the burst in progress is unaffected.
REQ-024 CLEAR: puf_challenge = challenge register; after exactly CLEAR_CYCLES cycles go to SETTLE.
REQ-025 SETTLE: after exactly SETTLE_CYCLES cycles go to WAIT; puf_done ignored in SETTLE.
REQ-026 WAIT: puf_done=1 captures puf_response into resp_data, clears resp_timeout, goes to OUTPUT next cycle.
REQ-027 WAIT: if puf_done stays 0 for TIMEOUT_CYCLES cycles, resp_data=8'h00, resp_timeout=1, go to OUTPUT.
REQ-028 puf_done and timeout expiry in the same cycle: puf_done wins (resp_timeout=0).
REQ-029 OUTPUT: resp_valid=1; resp_data, resp_index, resp_timeout held stable until resp_valid&resp_ready.
REQ-030 OUTPUT handshake, not last: challenge register increments by 1 modulo 256 (8'hFF wraps to 8'h00), index increments; next state CLEAR.
REQ-031 OUTPUT handshake, last (index = effective length-1): burst_done=1 for one cycle, next state IDLE.
REQ-032 resp_valid deasserts the cycle after handshake; never asserted outside OUTPUT.
REQ-033 puf_challenge holds its value through CLEAR, SETTLE, WAIT, OUTPUT of one step.
REQ-034 Each per-state counter clears on state entry; counter widths sized to their parameter.

Reset
REQ-035 reset=0 at a clock edge forces IDLE from any state, including mid-burst.
REQ-036 Reset values: busy=0, puf_enable=0, puf_reset=1, puf_challenge=0, resp_valid=0, resp_data=0, resp_index=0, resp_timeout=0, burst_done=0; all counters 0.
REQ-037 start sampled while reset=0 is ignored.

Verification (CLEAR_CYCLES=2, SETTLE_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-038 Single step: start, base=8'h3C, num=1; puf_done with response 8'hA5 three cycles into WAIT, resp_ready=1 -> resp_data=8'hA5, index=0, timeout=0, burst_done one cycle after handshake, busy low next cycle.
REQ-039 Wrap: base=8'hFE, num=3, responses 8'h01,8'h02,8'h03 -> puf_challenge sequence FE,FF,00; indices 0,1,2; single burst_done.
REQ-040 Timeout: num=1, puf_done never asserted -> OUTPUT exactly 20 cycles after WAIT entry, resp_data=8'h00, resp_timeout=1.
REQ-041 Backpressure: resp_ready low for 10 cycles in OUTPUT -> resp_valid and all resp_* stable 10 cycles, no CLEAR entry until handshake; start pulses meanwhile ignored.
REQ-042 num_challenges=0 -> exactly 16 responses, indices 0..15, then IDLE.
REQ-043 reset=0 during WAIT of step 2 -> next cycle all outputs at reset values, puf_enable=0; new start runs from base_challenge with index 0.
